// File: rtl/axi_mm2s_reader.sv
// AXI4 read initiator: splits (address, beat count) commands into INCR bursts and streams the data.
// Define AXI_MM2S_READER_CHECK_EN to add rid/rlast checking and the proto_err output.
module axi_mm2s_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned AXI_ID     = 0,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                    axi_clk,
    input  logic                    axi_resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_beats,
    output logic                    done,
    output logic                    err,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep
`ifdef AXI_MM2S_READER_CHECK_EN
    ,
    output logic                    proto_err
`endif
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(BYTES);
    localparam int unsigned BW       = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
    logic [8:0]             burst_cnt_q, burst_cnt_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;

    logic [12:0]            page_bytes;
    logic [BW-1:0]          page_beats;
    logic [BW-1:0]          burst_w;
    logic [8:0]             burst;
    logic                   r_fire;
    logic                   beat_mismatch;
    logic                   unused_sig;

    // Beats left before the next 4 KB page, then clamp by remaining and MAX_BURST.
    always_comb begin
        page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
        page_beats = BW'(page_bytes >> ADDR_LSB);
        burst_w    = BW'(remaining_q);
        if (burst_w > BW'(MAX_BURST)) burst_w = BW'(MAX_BURST);
        if (burst_w > page_beats)     burst_w = page_beats;
        burst      = 9'(burst_w);
    end

    assign r_fire = (state_q == StData) && m_axi_rvalid && m_axis_tready;

`ifdef AXI_MM2S_READER_CHECK_EN
    logic proto_err_q;

    assign beat_mismatch = (m_axi_rid != ID_WIDTH'(AXI_ID)) ||
                           (m_axi_rlast != (burst_cnt_q == 9'd1));
    assign unused_sig    = m_axi_rresp[0];
    assign proto_err     = proto_err_q;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            proto_err_q <= 1'b0;
        end else if (r_fire && beat_mismatch) begin
            proto_err_q <= 1'b1;
        end
    end
`else
    assign beat_mismatch = 1'b0;
    assign unused_sig    = ^{m_axi_rresp[0], m_axi_rid, m_axi_rlast};
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        burst_cnt_d   = burst_cnt_q;
        err_d         = err_q;
        done_d        = 1'b0;
        cmd_ready     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Hold off a new command during the done cycle so err stays readable.
                cmd_ready = !done_q;
                if (cmd_valid && !done_q) begin
                    addr_d      = cmd_addr & ~ADDR_MASK;
                    remaining_d = cmd_beats;
                    err_d       = 1'b0;
                    if (cmd_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    burst_cnt_d = burst;
                    addr_d      = addr_q + (ADDR_WIDTH'(burst) << ADDR_LSB);
                    state_d     = StData;
                end
            end
            StData: begin
                m_axis_tvalid = m_axi_rvalid;
                m_axi_rready  = m_axis_tready;
                m_axis_tlast  = (remaining_q == LEN_WIDTH'(1));
                if (r_fire) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    burst_cnt_d = burst_cnt_q - 9'd1;
                    err_d       = err_q | m_axi_rresp[1] | beat_mismatch;
                    if (burst_cnt_q == 9'd1) begin
                        if (remaining_q == LEN_WIDTH'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StAddr;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_cnt_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_cnt_q <= burst_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(burst - 9'd1);
    assign m_axi_arsize  = 3'(ADDR_LSB);
    assign m_axi_arburst = 2'b01;
    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tkeep  = '1;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_axi_mm2s_reader.sv
// Scoreboard bench for axi_mm2s_reader: AXI slave model plus stream sink, checked against a burst plan.
module tb_axi_mm2s_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic        done, err;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic        tlast;
    logic [3:0]  tkeep;
`ifdef AXI_MM2S_READER_CHECK_EN
    logic        proto_err;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int ar_count = 0;
    bit rand_tready = 1'b0;
    bit bad_en = 1'b0;
    logic [31:0] bad_addr = '0;

    logic [39:0] exp_ar[$];
    logic [32:0] exp_beat[$];
    logic [39:0] burst_q[$];

    always #5 clk = ~clk;

    axi_mm2s_reader dut (
        .axi_clk       (clk),
        .axi_resetn    (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .done          (done),
        .err           (err),
        .m_axi_arid    (arid),
        .m_axi_araddr  (araddr),
        .m_axi_arlen   (arlen),
        .m_axi_arsize  (arsize),
        .m_axi_arburst (arburst),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rid     (8'h00),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rlast   (rlast),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .m_axis_tkeep  (tkeep)
`ifdef AXI_MM2S_READER_CHECK_EN
        ,
        .proto_err     (proto_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    // Expected AR and stream sequence for a command, 32-bit bus, MAX_BURST 16.
    task automatic plan_cmd(input logic [31:0] addr, input int beats);
        logic [31:0] a;
        int rem, page, b;
        a = addr & ~32'h3;
        rem = beats;
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 4;
            b = rem;
            if (b > 16) b = 16;
            if (b > page) b = page;
            exp_ar.push_back({a, 8'(b - 1)});
            for (int i = 0; i < b; i++)
                exp_beat.push_back({(rem - i) == 1, mem_word(a + 32'(4 * i))});
            a += 32'(4 * b);
            rem -= b;
        end
    endtask

    // AXI read slave: random arready, random rvalid gaps, rvalid held until accepted.
    initial begin
        logic [31:0] r_addr = '0;
        int r_left = 0;
        bit r_act = 1'b0;
        bit hs_r = 1'b0;
        bit prev_wait = 1'b0;
        logic [39:0] prev_ar = '0;
        logic [39:0] cur, e;
        forever begin
            @(negedge clk);
            hs_r = 1'b0;
            if (rst_n) begin
                cur = {araddr, arlen};
                if (arvalid) begin
                    if (prev_wait) check_eq("ar_hold", cur, prev_ar);
                    prev_wait = !arready;
                    prev_ar = cur;
                end else begin
                    prev_wait = 1'b0;
                end
                if (arvalid && arready) begin
                    ar_count++;
                    check_eq("ar_const", {arid, arburst, arsize}, {8'h00, 2'b01, 3'd2});
                    if (exp_ar.size() == 0) begin
                        check_eq("ar_unexpected", cur, 40'h0);
                    end else begin
                        e = exp_ar.pop_front();
                        check_eq("ar_addr_len", cur, e);
                    end
                    burst_q.push_back(cur);
                end
                if (rvalid && rready) begin
                    hs_r = 1'b1;
                    r_addr += 32'd4;
                    r_left--;
                    if (r_left == 0) r_act = 1'b0;
                end
            end else begin
                prev_wait = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                burst_q.delete();
                r_act = 1'b0;
                rvalid = 1'b0;
                arready = 1'b0;
            end else begin
                arready = ($urandom_range(0, 3) != 0);
                if (!r_act && burst_q.size() > 0) begin
                    cur = burst_q.pop_front();
                    r_addr = cur[39:8];
                    r_left = int'(cur[7:0]) + 1;
                    r_act = 1'b1;
                end
                if (r_act) begin
                    if (!(rvalid && !hs_r)) rvalid = ($urandom_range(0, 3) != 0);
                    rdata = mem_word(r_addr);
                    rlast = (r_left == 1);
                    rresp = (bad_en && r_addr == bad_addr) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0;
                end
            end
        end
    end

    // Stream sink and pass-through monitor.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rvalid) begin
                    check_eq("rready_mirror", rready, tready);
                    check_eq("tvalid_pass", tvalid, 1'b1);
                end
                if (tvalid && tready) begin
                    if (exp_beat.size() == 0) begin
                        check_eq("beat_unexpected", {tlast, tdata}, 33'h0);
                    end else begin
                        e = exp_beat.pop_front();
                        check_eq("beat_last_data", {tlast, tdata}, e);
                    end
                end
            end
            @(posedge clk);
            #1;
            tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input int beats);
        int k;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr = addr;
        cmd_beats = 16'(beats);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 100);
        check_eq("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int beats, input logic exp_err,
                           output int lat);
        plan_cmd(addr, beats);
        send_cmd(addr, beats);
        @(negedge clk);
        check_eq("err_clear", err, 1'b0);
        lat = 0;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check_eq("done_seen", done, 1'b1);
        check_eq("err_at_done", err, exp_err);
        check_eq("ar_remaining", exp_ar.size(), 0);
        check_eq("beats_remaining", exp_beat.size(), 0);
        @(negedge clk);
        check_eq("done_single", done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ar_before;
        repeat (3) @(negedge clk);
        check_eq("rst_arvalid", arvalid, 1'b0);
        check_eq("rst_tvalid", tvalid, 1'b0);
        check_eq("rst_rready", rready, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("tkeep", tkeep, 4'hF);
        @(posedge clk);
        #3 rst_n = 1'b1;

        run_cmd(32'h1000, 4, 1'b0, lat);
        run_cmd(32'h0, 40, 1'b0, lat);
        run_cmd(32'hFF8, 4, 1'b0, lat);
        run_cmd(32'h1003, 3, 1'b0, lat);
        rand_tready = 1'b1;
        run_cmd(32'h4000, 16, 1'b0, lat);
        bad_en = 1'b1;
        bad_addr = 32'h2004;
        run_cmd(32'h2000, 4, 1'b1, lat);
        bad_en = 1'b0;
        run_cmd(32'h3000, 4, 1'b0, lat);
        rand_tready = 1'b0;

        ar_before = ar_count;
        run_cmd(32'h7000, 0, 1'b0, lat);
        check_eq("zero_done_latency", lat, 0);
        repeat (3) @(negedge clk);
        check_eq("zero_no_ar", ar_count, ar_before);

        // Abort mid-DATA with reset.
        plan_cmd(32'h5000, 16);
        send_cmd(32'h5000, 16);
        for (int k = 0; k < 500 && exp_beat.size() > 12; k++) @(negedge clk);
        check_eq("mid_data_reached", exp_beat.size() <= 12, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort_arvalid", arvalid, 1'b0);
        check_eq("abort_tvalid", tvalid, 1'b0);
        check_eq("abort_rready", rready, 1'b0);
        exp_ar.delete();
        exp_beat.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cmd_ready", cmd_ready, 1'b1);
        run_cmd(32'h6000, 5, 1'b0, lat);
`ifdef AXI_MM2S_READER_CHECK_EN
        check_eq("proto_err", proto_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_mm2s_reader.md
Name: axi_mm2s_reader

Overview:
AXI4 read initiator that pairs with the team's AXI read responder blocks. It accepts a command of (address, beat count) and splits it into INCR read bursts. Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary. Returned read data is forwarded beat-for-beat onto an AXI-Stream master with tlast on the final beat of the command. Used as the memory-to-stream front end feeding stream sinks in the test harnesses.

Parameters:
DATA_WIDTH, 32, data bus width in bits (power of 2, 8..1024)
ADDR_WIDTH, 32, AXI address width
ID_WIDTH, 8, AXI ID width
AXI_ID, 0, constant value driven on m_axi_arid
MAX_BURST, 16, max beats per burst (power of 2, 1..256)
LEN_WIDTH, 16, width of command beat count

Ports:
axi_clk  in  1  sole clock
axi_resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored, treated as 0
cmd_beats  in  LEN_WIDTH  total beats to read
done  out  1  one-cycle pulse when the command completes
err  out  1  set if any beat of the command returned rresp[1]=1; valid when done is high; held until next command accept
m_axi_arid  out  ID_WIDTH  equals AXI_ID
m_axi_araddr  out  ADDR_WIDTH  burst start address
m_axi_arlen  out  8  burst beats minus 1
m_axi_arsize  out  3  constant log2(DATA_WIDTH/8)
m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rid  in  ID_WIDTH  read ID
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read valid
m_axi_rready  out  1  read ready
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tlast  out  1  last beat of command
m_axis_tkeep  out  DATA_WIDTH/8  constant all ones

Behaviour:
- States IDLE, ADDR, DATA. Reset state is IDLE.
- Reset values: arvalid=0, tvalid=0, rready=0, done=0, err=0, beat and address registers cleared.
- Reset asserted mid-operation aborts immediately and returns to IDLE. Any outstanding burst is abandoned; the interconnect is reset alongside.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: latch address (aligned), remaining=cmd_beats, clear err.
  - If cmd_beats==0: done pulses next cycle, stay IDLE, no AR issued.
  - Otherwise go to ADDR.
- ADDR:
  - burst = min(remaining, MAX_BURST, (4096 - addr[11:0]) / (DATA_WIDTH/8)), computed in at least 13 bits.
  - arvalid=1, araddr=addr, arlen=burst-1. All are stable while arvalid && !arready.
  - On arready: load burst_cnt=burst, addr += burst*(DATA_WIDTH/8), go to DATA.
  - Only one burst is outstanding at a time.
- DATA:
  - Zero-latency combinational pass-through: tvalid=rvalid, tdata=rdata, rready=tready. No buffering; a beat transfers only when rvalid && tready.
  - tlast = (remaining==1).
  - Each transfer: remaining--, burst_cnt--, err |= rresp[1].
  - On the transfer with burst_cnt==1: if remaining==1, go to IDLE and pulse done the next cycle (err valid then). Otherwise go to ADDR.
- cmd_ready=0 outside IDLE. A new command is accepted no earlier than the cycle after done.
- rid and rlast are ignored unless the optional feature is enabled.

Optional Feature:
AXI_MM2S_READER_CHECK_EN
- With: on each R transfer, flag a mismatch if rid != AXI_ID or rlast != (burst_cnt==1). A mismatch sets err (sticky for the command) and raises the extra output port proto_err (1 bit, sticky until reset).
- Without: the proto_err port is absent, no checks are made, and err reflects rresp only.

Test Plan:
- cmd addr 0x1000, beats 4, tready=1 -> one AR araddr 0x1000 arlen 3; 4 stream beats, tlast on beat 4 only; done pulses once; err=0.
- addr 0x0, beats 40, MAX_BURST 16 -> ARs 0x0/arlen 15, 0x40/arlen 15, 0x80/arlen 7; 40 beats in order; single tlast.
- addr 0xFF8, beats 4 (32-bit) -> AR 0xFF8 arlen 1, then AR 0x1000 arlen 1; no burst crosses 4 KB.
- tready toggled randomly during 16-beat read -> rready mirrors tready every cycle; all 16 data words arrive unchanged and in order.
- rresp=2'b10 on beat 2 of 4 -> stream still delivers 4 beats; err=1 at done; next command accept clears err.
- cmd_beats=0 -> no arvalid ever; done pulses the cycle after accept. Reset asserted during DATA -> arvalid/tvalid/rready drop immediately, cmd_ready=1 after release.
